conv_window_loader: RTL and testbench
=====================================

Name: conv_window_loader

Overview:
- Consumes the single-bit software write strobe driven by the Nios II Write_en PIO, plus the pixel value on a companion data PIO.
- Builds the 3x3 neighbourhood window for the downstream convolution datapath.
- Each 0->1 transition of the strobe accepts one pixel in raster order; two internal line buffers and a 3x3 register window produce a window-valid pulse whenever a full neighbourhood exists.
- Also tracks the frame position and flags end of frame.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- CNT_W, 16, width of column, row and pixel counters (must hold IMG_W*IMG_H)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- write_en  in  1  pixel strobe from the Write_en PIO (level; accept on rising edge)
- pixel_in  in  DATA_W  pixel value, stable while write_en rises
- soft_clear  in  1  synchronous restart of frame position
- win_out  out  9*DATA_W  3x3 window; slice [DATA_W*(3r+c) +: DATA_W] = pixel(row-2+r, col-2+c), index 8 = newest
- window_valid  out  1  one-cycle pulse, win_out valid
- frame_done  out  1  one-cycle pulse after last pixel of frame
- pixel_count  out  CNT_W  pixels accepted in current frame
- busy  out  1  high while 0 < pixel_count < IMG_W*IMG_H

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values: win_out 0, window_valid 0, frame_done 0, pixel_count 0, busy 0, col 0, row 0, edge register we_d 0.
- Line-buffer storage is not cleared by reset.
- Edge detect: accept = write_en & ~we_d; we_d <= write_en every cycle.
  - write_en already high when reset releases gives exactly one accept.
  - Maximum accept rate is one per 2 cycles, so no overflow is possible.
- On accept, in one cycle:
  - shift each window row left by one pixel;
  - new column = {lb1[col], lb0[col], pixel_in} for rows 0/1/2;
  - write lb1[col] <= lb0[col] and lb0[col] <= pixel_in;
  - increment pixel_count.
- Column/row counters:
  - col increments per accept; at col = IMG_W-1, col wraps to 0 and row increments.
  - At row = IMG_H-1 and col = IMG_W-1, both wrap to 0 and pixel_count returns to 0.
- Latency: window_valid pulses exactly 1 cycle after an accept whose pixel position has row>=2 and col>=2; win_out updates in the same cycle and holds until the next accept.
- frame_done: pulses 1 cycle after the accept of pixel (IMG_H-1, IMG_W-1), coincident with that pixel's window_valid.
- Windows per frame: exactly (IMG_W-2)*(IMG_H-2). No windows straddle a row boundary; stale left-edge columns are never exposed because col>=2 is required.
- busy: combinational from pixel_count.
- soft_clear:
  - next cycle col, row and pixel_count are 0; window_valid and frame_done are 0; win_out is held.
  - Takes priority over a simultaneous accept; that pixel is dropped.
  - we_d still tracks write_en.
- Reset mid-frame: all state returns to reset values immediately (async). The next accepted pixel is treated as (0,0).
- No arithmetic on pixel values; data passes through unmodified.

Test Plan:
- IMG_W=4, IMG_H=4; drive 16 pixels, value=16*row+col, strobe 0/1 each 2 cycles.
  - First window_valid after pixel (2,2) with win_out = 00,01,02,10,11,12,20,21,22 (index 0..8).
  - Exactly 4 window_valid pulses; frame_done with the pixel 0x33 window (11,12,13,21,22,23,31,32,33).
- Hold write_en high for 10 cycles after one edge -> only one pixel accepted; pixel_count = 1.
- Back-to-back frames: 32 pixels -> pixel_count wraps to 0 after 16; second frame gives 4 windows identical to the first given identical data; 2 frame_done pulses.
- Assert soft_clear on the same cycle as the accept of pixel (1,3) -> pixel dropped; pixel_count = 0, busy = 0; next pixel treated as (0,0); no window_valid until 11 further accepts.
- Assert reset mid-frame at pixel 9 with write_en high -> all outputs 0 immediately. After release, write_en still high gives one accept at (0,0); pixel_count = 1.
- IMG_W=3, IMG_H=3 build: 9 pixels -> single window_valid and frame_done in the same cycle; win_out holds all 9 inputs in raster order.

Source files
------------

// File: rtl/conv_window_loader.sv
// conv_window_loader: accepts PIO-strobed raster pixels and emits 3x3 neighbourhood windows
module conv_window_loader #(
  parameter int DATA_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic [DATA_W-1:0]   pixel_in,
  input  logic                soft_clear,
  output logic [9*DATA_W-1:0] win_out,
  output logic                window_valid,
  output logic                frame_done,
  output logic [CNT_W-1:0]    pixel_count,
  output logic                busy
);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic                     we_d;
  logic [CNT_W-1:0]         col, row;
  logic [8:0][DATA_W-1:0]   w;
  logic [DATA_W-1:0]        lb0 [IMG_W];
  logic [DATA_W-1:0]        lb1 [IMG_W];
  logic                     accept, take, last_col, last_row;
  logic [CW-1:0]            ci;
  assign accept = write_en & ~we_d;
  assign take = accept & ~soft_clear;
  assign last_col = col == LAST_COL;
  assign last_row = row == LAST_ROW;
  assign ci = col[CW-1:0];
  assign win_out = w;
  assign busy = pixel_count != '0 && pixel_count < TOTAL;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_d <= 1'b0;
      col <= '0;
      row <= '0;
      pixel_count <= '0;
      w <= '0;
      window_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we_d <= write_en;
      window_valid <= take && row >= TWO && col >= TWO;
      frame_done <= take && last_row && last_col;
      if (soft_clear) begin
        col <= '0;
        row <= '0;
        pixel_count <= '0;
      end else if (accept) begin
        w <= {pixel_in, w[8:7], lb0[ci], w[5:4], lb1[ci], w[2:1]};
        col <= last_col ? '0 : col + ONE;
        row <= last_col ? (last_row ? '0 : row + ONE) : row;
        pixel_count <= last_col && last_row ? '0 : pixel_count + ONE;
      end
    end
  always_ff @(posedge clk)
    if (take && !reset) begin
      lb1[ci] <= lb0[ci];
      lb0[ci] <= pixel_in;
    end
endmodule

// File: tb/tb_conv_window_loader.sv
// tb_conv_window_loader: scoreboard bench for 4x4 and 3x3 window loaders
module tb_conv_window_loader;
  typedef struct {
    logic [71:0] win;
    logic        fd;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        write_en = 1'b0, soft_clear = 1'b0, we3 = 1'b0;
  logic [7:0]  pixel_in = '0, px3 = '0;
  logic [71:0] win_out, win3;
  logic        window_valid, frame_done, busy, wv3, fd3, busy3;
  logic [15:0] pixel_count, cnt3;
  int          n_assert = 0, n_fail = 0;
  int          n_win = 0, n_fd = 0, n_win3 = 0, n_fd3 = 0;
  int          mr = 0, mc = 0;
  logic [7:0]  img [4][4];
  exp_t        q4[$], q3[$];
  always #5 clk = ~clk;
  conv_window_loader #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .pixel_in(pixel_in),
    .soft_clear(soft_clear), .win_out(win_out), .window_valid(window_valid),
    .frame_done(frame_done), .pixel_count(pixel_count), .busy(busy)
  );
  conv_window_loader #(.DATA_W(8), .IMG_W(3), .IMG_H(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .write_en(we3), .pixel_in(px3),
    .soft_clear(1'b0), .win_out(win3), .window_valid(wv3),
    .frame_done(fd3), .pixel_count(cnt3), .busy(busy3)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [7:0] v);
    exp_t e;
    img[mr][mc] = v;
    if (mr >= 2 && mc >= 2) begin
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[8*(3*r+c) +: 8] = img[mr-2+r][mc-2+c];
      e.fd = (mr == 3 && mc == 3);
      q4.push_back(e);
    end
    if (mc == 3) begin
      mc = 0;
      mr = (mr == 3) ? 0 : mr + 1;
    end else mc++;
  endtask
  task automatic send4(input logic [7:0] v);
    @(negedge clk);
    write_en = 1'b1;
    pixel_in = v;
    model(v);
    @(negedge clk);
    @(negedge clk);
    write_en = 1'b0;
    @(negedge clk);
  endtask
  task automatic send3(input logic [7:0] v);
    @(negedge clk);
    we3 = 1'b1;
    px3 = v;
    @(negedge clk);
    @(negedge clk);
    we3 = 1'b0;
    @(negedge clk);
  endtask
  task automatic clear();
    @(negedge clk);
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    mr = 0;
    mc = 0;
  endtask
  always @(negedge clk) begin
    if (window_valid) begin
      n_win++;
      if (q4.size() == 0) chk("unexpected_window", 72'(window_valid), 72'(0));
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("win_out", win_out, e.win);
        chk("frame_done_with_window", 72'(frame_done), 72'(e.fd));
      end
    end
    if (frame_done) begin
      n_fd++;
      if (!window_valid) chk("frame_done_without_window", 72'(window_valid), 72'(1));
    end
    if (wv3) begin
      n_win3++;
      if (q3.size() == 0) chk("unexpected_window3", 72'(wv3), 72'(0));
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("win3", win3, e.win);
        chk("fd3_with_window", 72'(fd3), 72'(e.fd));
      end
    end
    if (fd3) n_fd3++;
  end
  initial begin
    int nw;
    @(negedge clk);
    chk("rst_win", win_out, 72'(0));
    chk("rst_valid", 72'(window_valid), 72'(0));
    chk("rst_fd", 72'(frame_done), 72'(0));
    chk("rst_count", 72'(pixel_count), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send4(8'(16 * (i / 4) + i % 4));
      if (i == 0) begin
        chk("count_first", 72'(pixel_count), 72'(1));
        chk("busy_first", 72'(busy), 72'(1));
      end
    end
    chk("frame1_windows", 72'(n_win), 72'(4));
    chk("frame1_fd", 72'(n_fd), 72'(1));
    chk("frame1_count_wrap", 72'(pixel_count), 72'(0));
    chk("frame1_busy", 72'(busy), 72'(0));
    @(negedge clk);
    write_en = 1'b1;
    pixel_in = 8'hAA;
    model(8'hAA);
    repeat (10) @(negedge clk);
    write_en = 1'b0;
    @(negedge clk);
    chk("hold_single_accept", 72'(pixel_count), 72'(1));
    clear();
    @(negedge clk);
    chk("clear_count", 72'(pixel_count), 72'(0));
    for (int i = 0; i < 32; i++) begin
      send4(8'(16 * ((i % 16) / 4) + i % 4));
      if (i == 15) chk("b2b_wrap", 72'(pixel_count), 72'(0));
    end
    chk("b2b_windows", 72'(n_win), 72'(12));
    chk("b2b_fd", 72'(n_fd), 72'(3));
    clear();
    for (int i = 0; i < 7; i++) send4(8'(8'h60 + i));
    @(negedge clk);
    write_en = 1'b1;
    pixel_in = 8'h77;
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    chk("sc_count", 72'(pixel_count), 72'(0));
    chk("sc_busy", 72'(busy), 72'(0));
    write_en = 1'b0;
    mr = 0;
    mc = 0;
    @(negedge clk);
    nw = n_win;
    for (int i = 0; i < 10; i++) send4(8'(8'h80 + i));
    chk("sc_no_early_window", 72'(n_win), 72'(nw));
    send4(8'h8A);
    @(negedge clk);
    chk("sc_window_after_11", 72'(n_win), 72'(nw + 1));
    clear();
    for (int i = 0; i < 9; i++) send4(8'(8'h40 + i));
    @(negedge clk);
    write_en = 1'b1;
    pixel_in = 8'h49;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_win", win_out, 72'(0));
    chk("mid_rst_valid", 72'(window_valid), 72'(0));
    chk("mid_rst_count", 72'(pixel_count), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mr = 0;
    mc = 0;
    model(8'h49);
    @(negedge clk);
    chk("post_rst_count", 72'(pixel_count), 72'(1));
    repeat (3) @(negedge clk);
    write_en = 1'b0;
    @(negedge clk);
    chk("post_rst_single", 72'(pixel_count), 72'(1));
    chk("post_rst_busy", 72'(busy), 72'(1));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        exp_t e;
        for (int k = 0; k < 9; k++) e.win[8*k +: 8] = 8'(8'hA0 + k);
        e.fd = 1'b1;
        q3.push_back(e);
      end
      send3(8'(8'hA0 + i));
    end
    chk("img3_windows", 72'(n_win3), 72'(1));
    chk("img3_fd", 72'(n_fd3), 72'(1));
    chk("img3_count_wrap", 72'(cnt3), 72'(0));
    chk("q4_drained", 72'(q4.size()), 72'(0));
    chk("q3_drained", 72'(q3.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
